// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, frame geometry, default bit timing.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DATA_W       = 8;
    localparam int UART_FRAME_BITS   = 10;
    localparam int UART_CLKS_PER_BIT = 5208;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-timing enable: one-cycle tick every CLKS_PER_BIT cycles while not cleared.
// Latency: tick on the CLKS_PER_BIT-th cycle after clear drops.
// Backpressure: none; clear holds the counter at zero.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Tick on the last count of a bit; wrap to zero there so the counter never overflows.
    always_comb begin
        tick  = ~clear & (cnt_q == LAST_CNT);
        cnt_d = cnt_q + 16'd1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin arbiter feeding one 8N1 UART transmitter.
// Latency: req_ready one cycle after an IDLE decision; start bit the cycle after req_ready.
// Backpressure: requesters hold req_valid/req_data until their one-cycle req_ready strobe.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int NUM_REQ      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [2:0]             grant_id
);

    uart_state_e              state_q, state_d;
    logic [UART_DATA_W-1:0]   shift_q, shift_d;
    logic [2:0]               bit_cnt_q, bit_cnt_d;
    logic [2:0]               rr_last_q, rr_last_d;
    logic [2:0]               grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0]       req_ready_q, req_ready_d;
    logic                     tx_q, tx_d;
    logic                     busy_q, busy_d;

    logic                     tick;
    logic                     baud_clear;
    logic                     win_found;
    logic [2:0]               win_idx;
    logic [7:0]               valid_ext;
    logic [63:0]              data_ext;

    assign valid_ext = 8'(req_valid);
    assign data_ext  = 64'(req_data);

    // Bit timing runs only while a frame is on the line.
    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (baud_clear),
        .tick  (tick)
    );

    // Round-robin search starting just after the last winner; the nearest valid requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_last_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (valid_ext[3'((int'(rr_last_q) + k) % NUM_REQ)]) begin
                win_found = 1'b1;
                win_idx   = 3'((int'(rr_last_q) + k) % NUM_REQ);
            end
        end
    end

    // Frame sequencer next state; line outputs are registered from the current state, so they lag it by one cycle.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        rr_last_d   = rr_last_q;
        grant_id_d  = grant_id_q;
        req_ready_d = '0;
        baud_clear  = 1'b0;
        tx_d        = 1'b1;
        busy_d      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                baud_clear = 1'b1;
                if (win_found) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        req_ready_d[i] = (3'(i) == win_idx);
                    end
                    shift_d    = data_ext[{win_idx, 3'b000} +: 8];
                    grant_id_d = win_idx;
                    rr_last_d  = win_idx;
                    state_d    = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'(UART_DATA_W - 1)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            rr_last_q   <= 3'(NUM_REQ - 1);
            grant_id_q  <= '0;
            req_ready_q <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            rr_last_q   <= rr_last_d;
            grant_id_q  <= grant_id_d;
            req_ready_q <= req_ready_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: fast-timing instance for function, default-timing instance for bit length.
// Latency: n/a.
// Backpressure: bench requesters hold valid/data until they see req_ready.
module tb_uart_tx_sched;
    import uart_pkg::*;

    localparam int N     = 4;
    localparam int CPB   = 4;
    localparam int CPB_D = 5208;

    logic           clk = 1'b0;
    logic           rst = 1'b1;

    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data  = '0;
    logic [N-1:0]   req_ready;
    logic           tx, busy;
    logic [2:0]     grant_id;

    logic [N-1:0]   req_valid_b = '0;
    logic [8*N-1:0] req_data_b  = '0;
    logic [N-1:0]   req_ready_b;
    logic           tx_b, busy_b;
    logic [2:0]     grant_id_b;

    int checks = 0;
    int errors = 0;
    int rr_last_m = N - 1;

    always #5 clk = ~clk;

    uart_tx_sched #(.CLKS_PER_BIT(CPB), .NUM_REQ(N)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx(tx), .busy(busy), .grant_id(grant_id)
    );

    uart_tx_sched #(.CLKS_PER_BIT(CPB_D), .NUM_REQ(N)) dut_def (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_data(req_data_b),
        .req_ready(req_ready_b), .tx(tx_b), .busy(busy_b), .grant_id(grant_id_b)
    );

    // Reference rule: first valid requester after the last winner, modulo N.
    function automatic int pick(input logic [N-1:0] mask, input int last);
        for (int k = 1; k <= N; k++) begin
            if (mask[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Line bits in transmit order, index 0 first: start 0, data LSB first, stop 1.
    function automatic logic [9:0] frame_of(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rr_last_m = N - 1;
    endtask

    task automatic wait_grant(input int sel, input int max, output logic [N-1:0] rdy, output int waited);
        rdy = '0;
        waited = 0;
        while (waited < max) begin
            @(negedge clk);
            waited++;
            rdy = (sel != 0) ? req_ready_b : req_ready;
            if (rdy != '0) break;
        end
    endtask

    // Observes the 10-bit window that starts the cycle after req_ready.
    task automatic capture_frame(input int sel, input int cpb, output logic [9:0] bits,
                                 output int busy_cnt, output int glitches, output int extra_rdy);
        logic t, first;
        bits = '0; busy_cnt = 0; glitches = 0; extra_rdy = 0; first = 1'b0;
        for (int c = 0; c < 10 * cpb; c++) begin
            @(negedge clk);
            t = (sel != 0) ? tx_b : tx;
            if (((sel != 0) ? busy_b : busy) === 1'b1) busy_cnt++;
            if (((sel != 0) ? req_ready_b : req_ready) != '0) extra_rdy++;
            if (c % cpb == 0) first = t;
            else if (t !== first) glitches++;
            if (c % cpb == cpb / 2) bits[c / cpb] = t;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got %b exp 0", req_ready); end
        checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_grant_id got %0d exp 0", grant_id); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [N-1:0] rdy; logic [9:0] bits; int w, bc, gl, xr, exp_w;
        req_data[7:0] = 8'hA5;
        req_valid = 4'b0001;
        wait_grant(0, 20, rdy, w);
        exp_w = pick(4'b0001, rr_last_m); rr_last_m = exp_w;
        req_valid = '0;
        checks++; if (rdy !== onehot(exp_w)) begin errors++; $display("FAIL single_ready got %b exp %b", rdy, onehot(exp_w)); end
        checks++; if (grant_id !== 3'(exp_w)) begin errors++; $display("FAIL single_grant_id got %0d exp %0d", grant_id, exp_w); end
        capture_frame(0, CPB, bits, bc, gl, xr);
        checks++; if (bits !== frame_of(8'hA5)) begin errors++; $display("FAIL single_bits got %b exp %b", bits, frame_of(8'hA5)); end
        checks++; if (bc !== 10 * CPB) begin errors++; $display("FAIL single_busy_len got %0d exp %0d", bc, 10 * CPB); end
        checks++; if (gl !== 0) begin errors++; $display("FAIL single_bit_shape got %0d exp 0", gl); end
        checks++; if (xr !== 0) begin errors++; $display("FAIL single_ready_width got %0d exp 0", xr); end
        @(negedge clk);
        checks++; if ({busy, tx} !== 2'b01) begin errors++; $display("FAIL single_post_frame got busy=%b tx=%b exp busy=0 tx=1", busy, tx); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] rdy; logic [9:0] bits; int w, bc, gl, xr, exp_w;
        do_reset();
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'(8'h10 + i);
        req_valid = '1;
        for (int f = 0; f < 5; f++) begin
            wait_grant(0, 60, rdy, w);
            exp_w = pick(req_valid, rr_last_m); rr_last_m = exp_w;
            if (f == 4) req_valid = '0;
            checks++; if (rdy !== onehot(exp_w)) begin errors++; $display("FAIL rr_order frame %0d got %b exp %b", f, rdy, onehot(exp_w)); end
            if (f > 0) begin
                checks++; if (10 * CPB + w !== 10 * CPB + 1) begin errors++; $display("FAIL rr_period frame %0d got %0d exp %0d", f, 10 * CPB + w, 10 * CPB + 1); end
            end
            capture_frame(0, CPB, bits, bc, gl, xr);
            checks++; if (bits !== frame_of(8'(8'h10 + exp_w))) begin errors++; $display("FAIL rr_bits frame %0d got %b exp %b", f, bits, frame_of(8'(8'h10 + exp_w))); end
        end
    endtask

    task automatic test_fairness_skip();
        logic [N-1:0] rdy; logic [9:0] bits; logic [7:0] exp_d; int w, bc, gl, xr, exp_w;
        do_reset();
        req_data[23:16] = 8'($urandom);
        req_valid = 4'b0100;
        for (int f = 0; f < 3; f++) begin
            wait_grant(0, 60, rdy, w);
            exp_w = pick(req_valid, rr_last_m); rr_last_m = exp_w;
            exp_d = req_data[8*exp_w +: 8];
            checks++; if (rdy !== onehot(exp_w)) begin errors++; $display("FAIL skip_grant step %0d got %b exp %b", f, rdy, onehot(exp_w)); end
            req_valid[exp_w] = 1'b0;
            if (f == 0) begin
                req_data[7:0]   = 8'($urandom);
                req_data[23:16] = 8'($urandom);
                req_valid = 4'b0101;
            end
            capture_frame(0, CPB, bits, bc, gl, xr);
            checks++; if (bits !== frame_of(exp_d)) begin errors++; $display("FAIL skip_bits step %0d got %b exp %b", f, bits, frame_of(exp_d)); end
            checks++; if (xr !== 0) begin errors++; $display("FAIL skip_stray_ready step %0d got %0d exp 0", f, xr); end
        end
    endtask

    task automatic test_mid_reset();
        logic [N-1:0] rdy; logic [9:0] bits; logic [7:0] exp_d; int w, bc, gl, xr, exp_w;
        do_reset();
        req_data[15:8] = 8'hF0;
        req_valid = 4'b0010;
        wait_grant(0, 20, rdy, w);
        req_valid = '0;
        repeat (18) @(negedge clk);
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midrst_pre_tx got %b exp 0", tx); end
        #1 rst = 1'b1;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b exp 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rr_last_m = N - 1;
        req_data[7:0]  = 8'($urandom);
        req_data[15:8] = 8'($urandom);
        req_valid = 4'b0011;
        for (int f = 0; f < 2; f++) begin
            wait_grant(0, 60, rdy, w);
            exp_w = pick(req_valid, rr_last_m); rr_last_m = exp_w;
            exp_d = req_data[8*exp_w +: 8];
            req_valid[exp_w] = 1'b0;
            checks++; if (rdy !== onehot(exp_w)) begin errors++; $display("FAIL midrst_grant step %0d got %b exp %b", f, rdy, onehot(exp_w)); end
            capture_frame(0, CPB, bits, bc, gl, xr);
            checks++; if (bits !== frame_of(exp_d) || gl !== 0) begin errors++; $display("FAIL midrst_frame step %0d got %b glitches %0d exp %b", f, bits, gl, frame_of(exp_d)); end
        end
    endtask

    task automatic test_withdraw();
        logic [N-1:0] rdy; logic [9:0] bits; logic [7:0] exp_d; int w, bc, gl, xr, n_rdy, n_low, n_busy;
        do_reset();
        exp_d = 8'($urandom);
        req_data[7:0] = exp_d;
        req_valid = 4'b0001;
        wait_grant(0, 20, rdy, w);
        req_valid = '0;
        fork
            capture_frame(0, CPB, bits, bc, gl, xr);
            begin
                repeat (10) @(negedge clk);
                req_data[31:24] = 8'($urandom);
                req_valid[3] = 1'b1;
                repeat (8) @(negedge clk);
                req_valid[3] = 1'b0;
            end
        join
        checks++; if (bits !== frame_of(exp_d)) begin errors++; $display("FAIL withdraw_bits got %b exp %b", bits, frame_of(exp_d)); end
        n_rdy = 0; n_low = 0; n_busy = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (req_ready != '0) n_rdy++;
            if (tx !== 1'b1) n_low++;
            if (busy !== 1'b0) n_busy++;
        end
        checks++; if (n_rdy !== 0) begin errors++; $display("FAIL withdraw_ready got %0d exp 0", n_rdy); end
        checks++; if (n_low !== 0) begin errors++; $display("FAIL idle_tx_low got %0d exp 0", n_low); end
        checks++; if (n_busy !== 0) begin errors++; $display("FAIL idle_busy got %0d exp 0", n_busy); end
    endtask

    task automatic test_random();
        logic [N-1:0] rdy; logic [9:0] bits; logic [7:0] exp_d; int w, bc, gl, xr, exp_w;
        do_reset();
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
                    req_data[8*i +: 8] = 8'($urandom);
                    req_valid[i] = 1'b1;
                end
            end
            if (req_valid == '0) begin
                w = $urandom_range(N - 1, 0);
                req_data[8*w +: 8] = 8'($urandom);
                req_valid[w] = 1'b1;
            end
            wait_grant(0, 60, rdy, w);
            exp_w = pick(req_valid, rr_last_m); rr_last_m = exp_w;
            exp_d = req_data[8*exp_w +: 8];
            req_valid[exp_w] = 1'b0;
            req_data[8*exp_w +: 8] = ~exp_d;
            checks++; if (rdy !== onehot(exp_w)) begin errors++; $display("FAIL rand_grant iter %0d got %b exp %b", it, rdy, onehot(exp_w)); end
            capture_frame(0, CPB, bits, bc, gl, xr);
            checks++; if (bits !== frame_of(exp_d) || gl !== 0 || bc !== 10 * CPB) begin
                errors++; $display("FAIL rand_frame iter %0d got %b busy %0d glitches %0d exp %b busy %0d", it, bits, bc, gl, frame_of(exp_d), 10 * CPB);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_default_timing();
        logic [N-1:0] rdy; logic [9:0] bits; int w, bc, gl, xr;
        req_data_b[7:0] = 8'h00;
        req_valid_b = 4'b0001;
        wait_grant(1, 20, rdy, w);
        req_valid_b = '0;
        checks++; if (rdy !== 4'b0001) begin errors++; $display("FAIL def_ready got %b exp 0001", rdy); end
        capture_frame(1, CPB_D, bits, bc, gl, xr);
        checks++; if (bits !== frame_of(8'h00)) begin errors++; $display("FAIL def_bits got %b exp %b", bits, frame_of(8'h00)); end
        checks++; if (bc !== UART_FRAME_BITS * CPB_D) begin errors++; $display("FAIL def_frame_len got %0d exp %0d", bc, UART_FRAME_BITS * CPB_D); end
        checks++; if (gl !== 0) begin errors++; $display("FAIL def_bit_len got %0d exp 0", gl); end
        @(negedge clk);
        checks++; if ({busy_b, tx_b} !== 2'b01) begin errors++; $display("FAIL def_post_frame got busy=%b tx=%b exp busy=0 tx=1", busy_b, tx_b); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness_skip();
        test_mid_reset();
        test_withdraw();
        test_random();
        test_default_timing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Shares one UART transmit line between NUM_REQ byte requesters using round-robin arbitration.
- Sequences each accepted byte as an 8N1 frame: start bit, 8 data bits LSB first, one stop bit.
- Generates its own bit timing with a clock-enable baud counter, not a derived clock.
- Sits between the UART producer logic and the tx pin; replaces free-running baud-clock usage on the Tx path.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per UART bit (50 MHz / 9600 baud); legal range 2..65535.
- NUM_REQ, 4, number of requesters; legal range 2..8.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  bit i high: requester i has a byte to send.
- req_data  in  8*NUM_REQ  byte for requester i at bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot, single-cycle accept strobe to the granted requester.
- tx  out  1  serial line, idle high.
- busy  out  1  high while a frame is in progress (START, DATA or STOP).
- grant_id  out  3  index of the requester whose frame is on tx; valid while busy.

Behaviour:
- Reset values: tx=1, busy=0, req_ready=0, grant_id=0, state=IDLE, bit counter=0, baud counter=0, rr_last=NUM_REQ-1.
- rst acts immediately: asserting it mid-frame forces tx=1 and busy=0 at once and abandons the frame; no partial retransmit.
- State IDLE:
  - Requesters are examined in order rr_last+1, rr_last+2, … modulo NUM_REQ; the first with req_valid=1 wins.
  - In the same cycle: req_ready[winner]=1, data is latched into an 8-bit shift register, grant_id=winner, rr_last=winner.
  - Next state START; baud counter cleared.
  - With no req_valid, remain in IDLE with tx=1.
- State START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA with bit counter=0.
- State DATA:
  - tx = shift[0] for CLKS_PER_BIT cycles.
  - At the end of each bit, shift right and increment the bit counter.
  - After bit 7, go to STOP.
- State STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Timing:
  - First tx=0 cycle is the cycle after the req_ready pulse.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - At least 1 IDLE cycle separates consecutive frames, so back-to-back period is 10*CLKS_PER_BIT+1.
- Baud counter:
  - 16 bits; counts 0..CLKS_PER_BIT-1.
  - The bit-end tick fires at CLKS_PER_BIT-1, then the counter wraps to 0.
  - The counter never overflows.
- busy=1 exactly in START, DATA and STOP; it falls in the cycle IDLE is entered.
- req_ready is asserted only in IDLE, for one cycle, and never to a requester with req_valid=0.
- Handshake: a requester holds req_valid and req_data stable until it sees req_ready. Deassertion before the grant withdraws the request with no side effect.
- req_valid and req_data changes during a frame have no effect on the frame; the data is already latched.
- Fairness: a requester with req_valid held high is granted within NUM_REQ frames.
- All outputs are registered; tx has no combinational path from inputs.

Decomposition:
- Shared package uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP};
  - constants UART_DATA_W=8, UART_FRAME_BITS=10;
  - default CLKS_PER_BIT=5208.
- One sub-module, uart_baud_tick:
  - inputs clk, rst, clear; output tick;
  - parameter CLKS_PER_BIT;
  - a single-cycle enable, replacing toggled baud clocks on this path.
- Arbiter and frame FSM stay in uart_tx_sched.

Test Plan:
- Single frame (CLKS_PER_BIT=4): req_valid=0001, data0=0xA5 → req_ready=0001 for 1 cycle; tx sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1; busy high for 40 cycles.
- Round-robin (CLKS_PER_BIT=4): all four req_valid held high, data_i=0x10+i → grant order 0,1,2,3,0; each frame starts 41 cycles after the previous one.
- Fairness skip: only req 2 and req 0 valid after a grant to req 2 → next grant to req 0, then req 2; req 1 and req 3 never get req_ready.
- Mid-frame reset: assert rst during DATA bit 3 → tx=1 and busy=0 in the same cycle. After release with req 1 valid, its frame starts cleanly from rr_last=3, so req 0 has priority if also valid.
- Withdrawn request and idle hold: pulse req_valid[3] during a busy frame, then drop it before IDLE → no grant to 3 and no extra frame; tx stays 1 for 100 idle cycles.
- Default timing (CLKS_PER_BIT=5208): one byte 0x00 → start bit low for exactly 5208 cycles; full frame is 52080 cycles.
